sadd_ctrl: RTL and testbench



---
 rtl/sadd_ctrl.sv | 107 ++++++++++
 tb/tb_sadd_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sadd_ctrl.sv
// Word-level sequencer around a one-carry serial full adder: adds or subtracts
// two W-bit operands LSB-first over W cycles with a start/busy/done handshake.
module sadd_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  part_q, part_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_bit;
    logic [W:0]    part_ext;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
        // Slicing the extended vector keeps the shift-in legal for W=1.
        part_ext = {s_bit, part_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
                part_d  = part_ext[W:1];
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = part_ext[W:1];
                    cout_d  = carry_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Operand and partial-sum shifters are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        part_q <= part_d;
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_sadd_ctrl.sv
// Self-checking bench for sadd_ctrl: W=8 and W=1 instances, scoreboard queues
// filled when operations are issued and drained on each done pulse.
module tb_sadd_ctrl;

    logic       clk;
    logic       rst;
    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1, sub1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int vectors = 0;
    int errors  = 0;

    logic [8:0] exp8_q[$];
    logic [1:0] exp1_q[$];
    logic [7:0] prev8_sum;
    logic       prev8_cout;

    sadd_ctrl #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    sadd_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [8:0] full;
        if (s) return {(x >= y), 8'(x - y)};
        full = {1'b0, x} + {1'b0, y};
        return full;
    endfunction

    task automatic test_reset();
        rst    = 1'b1;
        start8 = 1'($urandom_range(1)); sub8 = 1'($urandom_range(1));
        a8     = 8'($urandom_range(255)); b8 = 8'($urandom_range(255));
        start1 = 1'($urandom_range(1)); sub1 = 1'($urandom_range(1));
        a1     = 1'($urandom_range(1)); b1 = 1'($urandom_range(1));
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b, required all 0", busy8, done8, sum8, cout8);
        end
        vectors++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            errors++;
            $display("FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b, required all 0", busy1, done1, sum1, cout1);
        end
        start8 = 1'b0; start1 = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy8, done8, sum8, cout8, busy1, done1, sum1, cout1} !== 15'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got w8 %b%b %h %b w1 %b%b %b %b, required all 0",
                         i, busy8, done8, sum8, cout8, busy1, done1, sum1, cout1);
            end
        end
        prev8_sum = 8'h00; prev8_cout = 1'b0;
    endtask

    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
        logic [8:0] e;
        int cyc;
        exp8_q.push_back(model8(ta, tb, ts));
        @(negedge clk);
        a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom_range(255)); b8 = 8'($urandom_range(255)); sub8 = ~ts;
        cyc = 0;
        while (busy8 === 1'b1 && cyc < 40) begin
            vectors++;
            if (sum8 !== prev8_sum || cout8 !== prev8_cout || done8 !== 1'b0) begin
                errors++;
                $display("FAIL hold_w8: got sum=%h cout=%b done=%b while busy, required sum=%h cout=%b done=0",
                         sum8, cout8, done8, prev8_sum, prev8_cout);
            end
            cyc++;
            @(negedge clk);
        end
        vectors++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL busy_len_w8: got %0d busy cycles, required 8", cyc);
        end
        e = (exp8_q.size() > 0) ? exp8_q.pop_front() : 9'h1XX;
        vectors++;
        if (done8 !== 1'b1) begin
            errors++;
            $display("FAIL done_w8: got done=%b after busy, required 1", done8);
        end
        vectors++;
        if ({cout8, sum8} !== e) begin
            errors++;
            $display("FAIL result_w8 %h %s %h: got sum=%h cout=%b, required sum=%h cout=%b",
                     ta, ts ? "-" : "+", tb, sum8, cout8, e[7:0], e[8]);
        end
        prev8_sum = e[7:0]; prev8_cout = e[8];
        @(negedge clk);
        vectors++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL done_width_w8: got done=%b second cycle, required 0", done8);
        end
    endtask

    task automatic run_op1(input logic ta, input logic tb, input logic ts);
        logic [1:0] e;
        int cyc;
        e = ts ? {(ta >= tb), ta ^ tb} : {ta & tb, ta ^ tb};
        exp1_q.push_back(e);
        @(negedge clk);
        a1 = ta; b1 = tb; sub1 = ts; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; a1 = ~ta; b1 = ~tb;
        cyc = 0;
        while (busy1 === 1'b1 && cyc < 10) begin
            cyc++;
            @(negedge clk);
        end
        vectors++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL busy_len_w1: got %0d busy cycles, required 1", cyc);
        end
        e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 2'bxx;
        vectors++;
        if (done1 !== 1'b1 || {cout1, sum1} !== e) begin
            errors++;
            $display("FAIL result_w1 %b %s %b: got done=%b sum=%b cout=%b, required done=1 sum=%b cout=%b",
                     ta, ts ? "-" : "+", tb, done1, sum1, cout1, e[0], e[1]);
        end
        @(negedge clk);
        vectors++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL done_width_w1: got done=%b, required 0", done1);
        end
    endtask

    task automatic test_add();
        run_op8(8'h5A, 8'h3C, 1'b0);
        run_op8(8'hFF, 8'h01, 1'b0);
        run_op8(8'h80, 8'h80, 1'b0);
    endtask

    task automatic test_sub();
        run_op8(8'h10, 8'h01, 1'b1);
        run_op8(8'h01, 8'h02, 1'b1);
        run_op8(8'h37, 8'h37, 1'b1);
    endtask

    task automatic test_back_to_back();
        int pulses, t1, t2;
        logic [8:0] e;
        pulses = 0; t1 = 0; t2 = 0;
        exp8_q.push_back(model8(8'h01, 8'h01, 1'b0));
        exp8_q.push_back(model8(8'hF0, 8'hF0, 1'b0));
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin a8 = 8'hF0; b8 = 8'hF0; end
            if (done8 === 1'b1) begin
                pulses++;
                if (pulses == 1) t1 = i; else t2 = i;
                e = (exp8_q.size() > 0) ? exp8_q.pop_front() : 9'h1XX;
                vectors++;
                if ({cout8, sum8} !== e) begin
                    errors++;
                    $display("FAIL b2b_result %0d: got sum=%h cout=%b, required sum=%h cout=%b",
                             pulses, sum8, cout8, e[7:0], e[8]);
                end
                prev8_sum = e[7:0]; prev8_cout = e[8];
            end
        end
        start8 = 1'b0;
        vectors++;
        if (pulses !== 2 || t1 !== 9) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses first at %0d, required 2 pulses first at 9", pulses, t1);
        end
        vectors++;
        if (t2 - t1 !== 10) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d, required 10", t2 - t1);
        end
        exp8_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int seen;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("FAIL midop_reset: got busy=%b done=%b sum=%h cout=%b, required all 0", busy8, done8, sum8, cout8);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midop_no_done: got %0d busy/done cycles after reset, required 0", seen);
        end
        prev8_sum = 8'h00; prev8_cout = 1'b0;
        run_op8(8'hAA, 8'h55, 1'b0);
    endtask

    task automatic test_w1();
        run_op1(1'b1, 1'b1, 1'b0);
        run_op1(1'b1, 1'b1, 1'b1);
        run_op1(1'b0, 1'b1, 1'b1);
        run_op1(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_midop();
        test_w1();
        for (int i = 0; i < 6; i++)
            run_op8(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
